// File: rtl/activity_led_mon.sv
// Multi-channel activity monitor: turns raw toggling lines and clk_sys strobes into
// retriggerable stretched flags, then merges the enabled channels into one LED drive.
module activity_led_mon #(
    parameter int CHANNELS     = 4,
    parameter int CNT_W        = 24,
    parameter int HOLD_CYCLES  = 1000000,
    parameter int BLINK_CYCLES = 4000000,
    parameter int POR_HOLD     = 1
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic [CHANNELS-1:0] act_in,
    input  logic [CHANNELS-1:0] pulse_in,
    input  logic [CHANNELS-1:0] chan_en,
    input  logic [1:0]          mode,
    output logic [CHANNELS-1:0] led_chan,
    output logic                led_any
);

    typedef enum logic [1:0] {
        MODE_STRETCH = 2'd0,
        MODE_BLINK   = 2'd1,
        MODE_OFF     = 2'd2,
        MODE_ON      = 2'd3
    } mode_t;

    localparam logic [CNT_W-1:0] HOLD_VAL   = CNT_W'(HOLD_CYCLES);
    localparam logic             POR_BIT    = (POR_HOLD != 0);
    localparam logic [CNT_W-1:0] POR_VAL    = POR_BIT ? HOLD_VAL : '0;
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYCLES - 1);

    logic [CHANNELS-1:0] sync1, sync2, hist, edge_q;
    logic [1:0]          arm;
    logic                armed;
    logic [CNT_W-1:0]    cnt      [CHANNELS];
    logic [CNT_W-1:0]    cnt_next [CHANNELS];
    logic [CHANNELS-1:0] ev;
    logic [CHANNELS-1:0] chan_on;
    logic                any_next;
    logic [CNT_W-1:0]    blink_cnt;
    logic                phase;

    assign armed = (arm == 2'd3);

    // A pulse and an act_in edge in the same cycle collapse into one reload.
    always_comb begin
        ev = edge_q | pulse_in;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_next[i] = cnt[i];
            if (ev[i]) begin
                cnt_next[i] = HOLD_VAL;
            end else if (cnt[i] != '0) begin
                cnt_next[i] = cnt[i] - CNT_W'(1);
            end
        end
        for (int i = 0; i < CHANNELS; i++) begin
            chan_on[i] = (cnt_next[i] != '0) & chan_en[i];
        end
        any_next = 1'b0;
        case (mode_t'(mode))
            MODE_STRETCH: any_next = |chan_on;
            MODE_BLINK:   any_next = (|chan_on) & phase;
            MODE_OFF:     any_next = 1'b0;
            MODE_ON:      any_next = 1'b1;
            default:      any_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            hist      <= '0;
            edge_q    <= '0;
            arm       <= 2'd0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= POR_VAL;
            end
            blink_cnt <= '0;
            phase     <= 1'b1;
            led_chan  <= {CHANNELS{POR_BIT}} & chan_en;
            led_any   <= 1'b0;
        end else begin
            sync1  <= act_in;
            sync2  <= sync1;
            hist   <= sync2;
            // Masking until armed hides the level a line already had at reset release.
            edge_q <= (sync2 ^ hist) & {CHANNELS{armed}};
            if (!armed) begin
                arm <= arm + 2'd1;
            end
            cnt <= cnt_next;
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + CNT_W'(1);
            end
            led_chan <= chan_on;
            led_any  <= any_next;
        end
    end

endmodule

// File: tb/tb_activity_led_mon.sv
// Bench for activity_led_mon: scenario tasks plus a randomized run, all checked against
// a last-event-time model of the stretch, blink and mode rules.
module tb_activity_led_mon;

    localparam int CH    = 4;
    localparam int CNT_W = 8;
    localparam int HOLD  = 8;
    localparam int BLINK = 4;
    localparam int POR   = 1;
    localparam int NO_EV = -100000;

    logic          clk_sys = 1'b0;
    logic          reset   = 1'b1;
    logic [CH-1:0] act_in  = '0;
    logic [CH-1:0] pulse_in = '0;
    logic [CH-1:0] chan_en = '1;
    logic [1:0]    mode    = 2'd0;
    logic [CH-1:0] led_chan;
    logic          led_any;

    int n_checks = 0;
    int n_pass   = 0;

    activity_led_mon #(
        .CHANNELS(CH), .CNT_W(CNT_W), .HOLD_CYCLES(HOLD),
        .BLINK_CYCLES(BLINK), .POR_HOLD(POR)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .act_in(act_in), .pulse_in(pulse_in),
        .chan_en(chan_en), .mode(mode), .led_chan(led_chan), .led_any(led_any)
    );

    always #5 clk_sys = ~clk_sys;

    // Model state: edges since reset release, act_in samples, and last event edge per channel.
    int            n_edge;
    logic [CH-1:0] act_q[$];
    int            last_ev[CH];
    logic [CH-1:0] exp_chan;
    logic          exp_any;

    function automatic logic [CH-1:0] act_at(int k);
        if (k < 0 || k >= act_q.size()) return '0;
        return act_q[k];
    endfunction

    // Advance one clock edge and update the expected outputs from the sampled inputs.
    task automatic tick();
        logic [CH-1:0] ev;
        logic [CH-1:0] active;
        logic          phase;
        @(posedge clk_sys);
        if (reset) begin
            act_q.delete();
            n_edge = 0;
            for (int i = 0; i < CH; i++) last_ev[i] = (POR != 0) ? -1 : NO_EV;
            exp_chan = ((POR != 0) ? {CH{1'b1}} : {CH{1'b0}}) & chan_en;
            exp_any  = 1'b0;
        end else begin
            act_q.push_back(act_in);
            ev = pulse_in;
            // An act_in change is seen three edges after sampling, and only once armed.
            if (n_edge >= 4) ev = ev | (act_at(n_edge - 3) ^ act_at(n_edge - 4));
            for (int i = 0; i < CH; i++) begin
                if (ev[i]) last_ev[i] = n_edge;
                active[i] = (n_edge - last_ev[i]) < HOLD;
            end
            exp_chan = active & chan_en;
            phase = ((n_edge / BLINK) % 2) == 0;
            case (mode)
                2'd0:    exp_any = |exp_chan;
                2'd1:    exp_any = (|exp_chan) & phase;
                2'd2:    exp_any = 1'b0;
                default: exp_any = 1'b1;
            endcase
            n_edge++;
        end
        #1;
    endtask

    task automatic apply_reset(int cycles);
        reset = 1'b1;
        repeat (cycles) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int hi;
        act_in = '0; pulse_in = '0; chan_en = 4'hF; mode = 2'd0;
        apply_reset(5);
        n_checks++;
        if (led_chan !== 4'hF || led_any !== 1'b0)
            $display("FAIL reset_state: led_chan=%b led_any=%b expected 1111/0", led_chan, led_any);
        else n_pass++;
        hi = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (led_chan === 4'hF && led_any === 1'b1) hi++;
            n_checks++;
            if (led_chan !== exp_chan || led_any !== exp_any)
                $display("FAIL por_hold c%0d: led_chan=%b led_any=%b expected %b/%b",
                         c, led_chan, led_any, exp_chan, exp_any);
            else n_pass++;
        end
        n_checks++;
        if (hi !== 7) $display("FAIL por_hold_len: got %0d lit edges expected 7", hi);
        else n_pass++;
    endtask

    task automatic test_pulse();
        int hi;
        hi = 0;
        for (int c = 0; c < 12; c++) begin
            pulse_in = (c == 0) ? 4'b0010 : 4'b0000;
            tick();
            if (led_chan === 4'b0010) hi++;
            n_checks++;
            if (led_chan !== exp_chan || led_any !== exp_any)
                $display("FAIL pulse c%0d: led_chan=%b led_any=%b expected %b/%b",
                         c, led_chan, led_any, exp_chan, exp_any);
            else n_pass++;
        end
        pulse_in = '0;
        n_checks++;
        if (hi !== HOLD) $display("FAIL pulse_len: got %0d expected %0d", hi, HOLD);
        else n_pass++;
    endtask

    task automatic test_act_static();
        int rise;
        act_in = 4'b0001;
        apply_reset(3);
        rise = -1;
        for (int c = 0; c < 20; c++) begin
            if (c == 10) act_in = 4'b0000;
            tick();
            if (c >= 7 && rise < 0 && led_chan[0] === 1'b1) rise = c;
            n_checks++;
            if (led_chan !== exp_chan || led_any !== exp_any)
                $display("FAIL act_static c%0d: led_chan=%b led_any=%b expected %b/%b",
                         c, led_chan, led_any, exp_chan, exp_any);
            else n_pass++;
        end
        n_checks++;
        if (rise !== 13) $display("FAIL act_rise: rose at %0d expected 13", rise);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int gaps;
        gaps = 0;
        for (int c = 0; c < 52; c++) begin
            pulse_in = (c % 8 == 0 && c < 40) ? 4'b0100 : 4'b0000;
            tick();
            if (c < 40 && led_chan[2] !== 1'b1) gaps++;
            n_checks++;
            if (led_chan !== exp_chan || led_any !== exp_any)
                $display("FAIL retrigger c%0d: led_chan=%b led_any=%b expected %b/%b",
                         c, led_chan, led_any, exp_chan, exp_any);
            else n_pass++;
        end
        pulse_in = '0;
        n_checks++;
        if (gaps !== 0) $display("FAIL retrigger_gap: got %0d gap cycles expected 0", gaps);
        else n_pass++;
    endtask

    task automatic test_modes();
        chan_en = 4'hF; mode = 2'd1; act_in = '0;
        apply_reset(2);
        for (int c = 0; c < 40; c++) begin
            if (c < 16)      begin mode = 2'd1; pulse_in = 4'b0001; end
            else if (c < 22) begin mode = 2'd2; pulse_in = 4'b0001; end
            else             begin mode = 2'd3; pulse_in = 4'b0000; end
            tick();
            n_checks++;
            if (led_chan !== exp_chan || led_any !== exp_any)
                $display("FAIL modes c%0d: led_chan=%b led_any=%b expected %b/%b",
                         c, led_chan, led_any, exp_chan, exp_any);
            else n_pass++;
        end
        mode = 2'd0;
    endtask

    task automatic test_chan_en();
        for (int c = 0; c < 12; c++) begin
            pulse_in = (c == 0) ? 4'b1000 : 4'b0000;
            chan_en  = (c >= 2 && c < 5) ? 4'b0111 : 4'b1111;
            tick();
            n_checks++;
            if (led_chan !== exp_chan || led_any !== exp_any)
                $display("FAIL chan_en c%0d: led_chan=%b led_any=%b expected %b/%b",
                         c, led_chan, led_any, exp_chan, exp_any);
            else n_pass++;
        end
        pulse_in = 4'b1111;
        tick();
        pulse_in = '0;
        repeat (3) tick();
        apply_reset(1);
        n_checks++;
        if (led_chan !== 4'hF || led_any !== 1'b0)
            $display("FAIL mid_reset: led_chan=%b led_any=%b expected 1111/0", led_chan, led_any);
        else n_pass++;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++;
            if (led_chan !== exp_chan || led_any !== exp_any)
                $display("FAIL mid_reset c%0d: led_chan=%b led_any=%b expected %b/%b",
                         c, led_chan, led_any, exp_chan, exp_any);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 249) == 0);
            for (int i = 0; i < CH; i++) begin
                pulse_in[i] = ($urandom_range(0, 14) == 0);
                if ($urandom_range(0, 11) == 0) act_in[i] = ~act_in[i];
            end
            if ($urandom_range(0, 19) == 0) chan_en = CH'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
            tick();
            n_checks++;
            if (led_chan !== exp_chan || led_any !== exp_any)
                $display("FAIL random c%0d: led_chan=%b led_any=%b expected %b/%b",
                         c, led_chan, led_any, exp_chan, exp_any);
            else n_pass++;
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pulse();
        test_act_static();
        test_back_to_back();
        test_modes();
        test_chan_en();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
